// File: rtl/matrix_ascii_encoder_if.sv
// Request, element-memory and UART-transmitter signals of the matrix ASCII encoder.
interface matrix_ascii_encoder_if;
  logic       start;
  logic [3:0] matrix_id;
  logic [2:0] dim_m;
  logic [2:0] dim_n;
  logic [4:0] elem_addr;
  logic [7:0] elem_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       done;
  logic       error;

  modport slave (
    input  start, matrix_id, dim_m, dim_n, elem_data, tx_busy,
    output elem_addr, tx_data, tx_start, busy, done, error
  );

  modport master (
    output start, matrix_id, dim_m, dim_n, elem_data, tx_busy,
    input  elem_addr, tx_data, tx_start, busy, done, error
  );
endinterface

// File: rtl/matrix_ascii_encoder.sv
// Streams a stored m x n matrix as an ASCII header plus decimal rows, one byte at a time,
// to a UART transmitter; all outputs are registered.
module matrix_ascii_encoder (
  input  logic                         clk,
  input  logic                         rst,
  matrix_ascii_encoder_if.slave        bus_io
);

  typedef enum logic [2:0] {IDLE, CHECK, HDR, FETCH, CONV, EMIT, WAIT, FIN} state_e;

  state_e     state_q, state_d;
  logic [3:0] id_q, id_d;
  logic [2:0] m_q, m_d, n_q, n_d;
  logic       bad_q, bad_d;
  logic [3:0] hdr_idx_q, hdr_idx_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [4:0] elem_cnt_q, elem_cnt_d;
  logic [3:0] dig_h_q, dig_h_d, dig_t_q, dig_t_d, dig_o_q, dig_o_d;
  logic [1:0] ndig_q, ndig_d;
  logic [2:0] pos_q, pos_d;
  logic       load_q, load_d, in_elem_q, in_elem_d, first_q, first_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d, busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic       last_col_s;
  logic [2:0] elem_len_s, row_nx_s, col_nx_s;
  logic [4:0] last_elem_s;

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [3:0] id,
                                          input logic [2:0] m, input logic [2:0] n);
    case (idx)
      4'd0:    hdr_byte = 8'h4D;
      4'd1:    hdr_byte = 8'h30 + {4'h0, id};
      4'd2:    hdr_byte = 8'h3A;
      4'd3:    hdr_byte = 8'h30 + {5'd0, m};
      4'd4:    hdr_byte = 8'h78;
      4'd5:    hdr_byte = 8'h30 + {5'd0, n};
      4'd6:    hdr_byte = 8'h0D;
      default: hdr_byte = 8'h0A;
    endcase
  endfunction

  // Digits are stored hundreds/tens/ones; sel skips the leading zeros.
  function automatic logic [7:0] elem_byte(input logic [2:0] pos, input logic [1:0] ndig,
                                           input logic [3:0] h, input logic [3:0] t,
                                           input logic [3:0] o, input logic last_col);
    logic [1:0] sel;
    sel = pos[1:0] + (2'd3 - ndig);
    if (pos < {1'b0, ndig}) begin
      case (sel)
        2'd0:    elem_byte = 8'h30 + {4'h0, h};
        2'd1:    elem_byte = 8'h30 + {4'h0, t};
        default: elem_byte = 8'h30 + {4'h0, o};
      endcase
    end else if (last_col) begin
      elem_byte = (pos == {1'b0, ndig}) ? 8'h0D : 8'h0A;
    end else begin
      elem_byte = 8'h20;
    end
  endfunction

  function automatic logic [4:0] addr_of(input logic [2:0] r, input logic [2:0] c,
                                         input logic [2:0] n);
    addr_of = ({2'b00, r} * {2'b00, n}) + {2'b00, c};
  endfunction

  // Derived per-element quantities and next row/column position.
  always_comb begin
    last_col_s  = (col_q == n_q - 3'd1);
    elem_len_s  = {1'b0, ndig_q} + (last_col_s ? 3'd2 : 3'd1);
    last_elem_s = ({2'b00, m_q} * {2'b00, n_q}) - 5'd1;
    if (last_col_s) begin
      row_nx_s = row_q + 3'd1;
      col_nx_s = 3'd0;
    end else begin
      row_nx_s = row_q;
      col_nx_s = col_q + 3'd1;
    end
  end

  // Next-state and output logic of the encoder FSM.
  always_comb begin
    state_d = state_q;    id_d = id_q;       m_d = m_q;           n_d = n_q;
    bad_d = bad_q;        hdr_idx_d = hdr_idx_q;
    row_d = row_q;        col_d = col_q;     elem_cnt_d = elem_cnt_q;
    dig_h_d = dig_h_q;    dig_t_d = dig_t_q; dig_o_d = dig_o_q;   ndig_d = ndig_q;
    pos_d = pos_q;        load_d = load_q;   in_elem_d = in_elem_q; first_d = first_q;
    addr_d = addr_q;      tx_data_d = tx_data_q;
    tx_start_d = 1'b0;    busy_d = busy_q;   done_d = 1'b0;       error_d = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        if (bus_io.start && !busy_q) begin
          id_d       = bus_io.matrix_id;
          m_d        = bus_io.dim_m;
          n_d        = bus_io.dim_n;
          bad_d      = (bus_io.matrix_id > 4'd9) || (bus_io.dim_m == 3'd0) ||
                       (bus_io.dim_m > 3'd5) || (bus_io.dim_n == 3'd0) || (bus_io.dim_n > 3'd5);
          error_d    = bad_d;
          busy_d     = 1'b1;
          hdr_idx_d  = 4'd0;
          row_d      = 3'd0;
          col_d      = 3'd0;
          elem_cnt_d = 5'd0;
          pos_d      = 3'd0;
          in_elem_d  = 1'b0;
          state_d    = CHECK;
        end else begin
          addr_d  = 5'd0;
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (bad_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!bus_io.tx_busy) begin
          tx_data_d  = hdr_byte(4'd0, id_q, m_q, n_q);
          tx_start_d = 1'b1;
          hdr_idx_d  = 4'd1;
          state_d    = EMIT;
        end else begin
          state_d = HDR;
        end
      end
      HDR: begin
        if (!bus_io.tx_busy) begin
          tx_data_d  = hdr_byte(hdr_idx_q, id_q, m_q, n_q);
          tx_start_d = 1'b1;
          hdr_idx_d  = hdr_idx_q + 4'd1;
          state_d    = EMIT;
        end else begin
          state_d = HDR;
        end
      end
      FETCH: begin
        load_d  = 1'b1;
        state_d = CONV;
      end
      CONV: begin
        if (load_q) begin
          dig_h_d   = 4'(bus_io.elem_data / 8'd100);
          dig_t_d   = 4'((bus_io.elem_data / 8'd10) % 8'd10);
          dig_o_d   = 4'(bus_io.elem_data % 8'd10);
          ndig_d    = (bus_io.elem_data >= 8'd100) ? 2'd3 :
                      ((bus_io.elem_data >= 8'd10) ? 2'd2 : 2'd1);
          pos_d     = 3'd0;
          load_d    = 1'b0;
          in_elem_d = 1'b1;
        end else if (!bus_io.tx_busy) begin
          tx_data_d  = elem_byte(pos_q, ndig_q, dig_h_q, dig_t_q, dig_o_q, last_col_s);
          tx_start_d = 1'b1;
          pos_d      = pos_q + 3'd1;
          state_d    = EMIT;
        end else begin
          state_d = CONV;
        end
      end
      EMIT: begin
        first_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // The UART may not raise tx_busy until a cycle after the strobe.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!bus_io.tx_busy) begin
          if (hdr_idx_q < 4'd8) begin
            state_d = HDR;
          end else if (!in_elem_q) begin
            addr_d  = addr_of(row_q, col_q, n_q);
            state_d = FETCH;
          end else if (pos_q < elem_len_s) begin
            state_d = CONV;
          end else if (elem_cnt_q >= last_elem_s) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            addr_d  = 5'd0;
            state_d = FIN;
          end else begin
            row_d      = row_nx_s;
            col_d      = col_nx_s;
            elem_cnt_d = elem_cnt_q + 5'd1;
            addr_d     = addr_of(row_nx_s, col_nx_s, n_q);
            state_d    = FETCH;
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        busy_d  = 1'b0;
        addr_d  = 5'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;   id_q <= 4'd0;      m_q <= 3'd0;        n_q <= 3'd0;
      bad_q <= 1'b0;     hdr_idx_q <= 4'd0;
      row_q <= 3'd0;     col_q <= 3'd0;     elem_cnt_q <= 5'd0;
      dig_h_q <= 4'd0;   dig_t_q <= 4'd0;   dig_o_q <= 4'd0;    ndig_q <= 2'd0;
      pos_q <= 3'd0;     load_q <= 1'b0;    in_elem_q <= 1'b0;  first_q <= 1'b0;
      addr_q <= 5'd0;    tx_data_q <= 8'd0; tx_start_q <= 1'b0;
      busy_q <= 1'b0;    done_q <= 1'b0;    error_q <= 1'b0;
    end else begin
      state_q <= state_d;   id_q <= id_d;           m_q <= m_d;           n_q <= n_d;
      bad_q <= bad_d;       hdr_idx_q <= hdr_idx_d;
      row_q <= row_d;       col_q <= col_d;         elem_cnt_q <= elem_cnt_d;
      dig_h_q <= dig_h_d;   dig_t_q <= dig_t_d;     dig_o_q <= dig_o_d;   ndig_q <= ndig_d;
      pos_q <= pos_d;       load_q <= load_d;       in_elem_q <= in_elem_d; first_q <= first_d;
      addr_q <= addr_d;     tx_data_q <= tx_data_d; tx_start_q <= tx_start_d;
      busy_q <= busy_d;     done_q <= done_d;       error_q <= error_d;
    end
  end

  assign bus_io.elem_addr = addr_q;
  assign bus_io.tx_data   = tx_data_q;
  assign bus_io.tx_start  = tx_start_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
  assign bus_io.error     = error_q;

endmodule

// File: tb/tb_matrix_ascii_encoder.sv
// Bench for matrix_ascii_encoder: UART and element-memory models plus a string-based
// reference of the expected ASCII stream.
module tb_matrix_ascii_encoder;
  logic clk;
  logic rst;

  matrix_ascii_encoder_if bus();

  matrix_ascii_encoder dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0]   mem [0:31];
  byte unsigned got[$];
  byte unsigned expq[$];
  int           tq[$];
  logic [4:0]   addrs[$];
  int done_cnt = 0, err_cnt = 0, viol_cnt = 0, both_cnt = 0;
  int busy_len = 0;
  int stall_at = -1;
  byte unsigned lit029 [0:10] = '{8'h4D, 8'h33, 8'h3A, 8'h31, 8'h78, 8'h31,
                                  8'h0D, 8'h0A, 8'h30, 8'h0D, 8'h0A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART transmitter and registered element memory, updated just after each rising edge.
  initial begin
    int busy_cnt;
    int cyc;
    logic [4:0] prev_addr;
    busy_cnt = 0;
    cyc = 0;
    prev_addr = 5'd0;
    bus.tx_busy = 1'b0;
    bus.elem_data = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.elem_data = mem[prev_addr];
      prev_addr = bus.elem_addr;
      bus.tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (bus.done) done_cnt++;
      if (bus.error) err_cnt++;
      if (bus.done && bus.error) both_cnt++;
      if (bus.busy && (addrs.size() == 0 || addrs[$] != bus.elem_addr))
        addrs.push_back(bus.elem_addr);
      if (bus.tx_start) begin
        if (bus.tx_busy) viol_cnt++;
        got.push_back(bus.tx_data);
        tq.push_back(cyc);
        busy_cnt = (got.size() == stall_at) ? 50 : busy_len;
      end
    end
  end

  task automatic build_exp(input int id, input int m, input int n);
    string s;
    s = $sformatf("M%0d:%0dx%0d\r\n", id, m, n);
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = {s, $sformatf("%0d", mem[r*n+c])};
        if (c == n - 1) s = {s, "\r\n"};
        else            s = {s, " "};
      end
    end
    expq.delete();
    for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tx_data"}, bus.tx_data, 8'd0);
    chk({tag, "_tx_start"}, bus.tx_start, 1'b0);
    chk({tag, "_elem_addr"}, bus.elem_addr, 5'd0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_error"}, bus.error, 1'b0);
  endtask

  task automatic do_start(input logic [3:0] id, input logic [2:0] m, input logic [2:0] n,
                          input logic exp_err);
    @(negedge clk);
    bus.start = 1'b1; bus.matrix_id = id; bus.dim_m = m; bus.dim_n = n;
    @(negedge clk);
    bus.start = 1'b0;
    bus.matrix_id = 4'($urandom); bus.dim_m = 3'($urandom); bus.dim_n = 3'($urandom);
    chk("check_busy", bus.busy, 1'b1);
    chk("check_error", bus.error, exp_err);
    chk("check_no_tx", bus.tx_start, 1'b0);
    @(negedge clk);
    if (exp_err) begin
      chk("err_clear", bus.error, 1'b0);
      chk("err_busy_low", bus.busy, 1'b0);
      chk("err_no_tx", bus.tx_start, 1'b0);
    end else begin
      chk("first_tx_latency", bus.tx_start, 1'b1);
      chk("first_tx_byte", bus.tx_data, 8'h4D);
    end
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after_done", bus.busy, 1'b0);
  endtask

  task automatic compare_stream();
    chk("stream_len", got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("byte%0d", i), got[i], expq[i]);
  endtask

  task automatic run_stream(input int id, input int m, input int n);
    int d0;
    got.delete(); tq.delete(); addrs.delete();
    build_exp(id, m, n);
    d0 = done_cnt;
    do_start(4'(id), 3'(m), 3'(n), 1'b0);
    wait_done(d0);
    compare_stream();
  endtask

  initial begin
    int d0, e0, n0;
    for (int i = 0; i < 32; i++) mem[i] = 8'd0;
    rst = 1'b1;
    bus.start = 1'b0; bus.matrix_id = 4'd0; bus.dim_m = 3'd0; bus.dim_n = 3'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1x1 matrix holding zero, slow UART; also against the literal byte list
    busy_len = 10;
    mem[0] = 8'd0;
    run_stream(3, 1, 1);
    for (int i = 0; i < 11 && i < got.size(); i++)
      chk($sformatf("lit_byte%0d", i), got[i], lit029[i]);

    // 2x2 with 1-, 2- and 3-digit values and address sequence
    busy_len = 2;
    mem[0] = 8'd5; mem[1] = 8'd10; mem[2] = 8'd100; mem[3] = 8'd255;
    run_stream(0, 2, 2);
    chk("addr_count", addrs.size(), 4);
    for (int i = 0; i < 4 && i < addrs.size(); i++)
      chk($sformatf("addr%0d", i), addrs[i], i);

    // illegal requests
    got.delete();
    e0 = err_cnt;
    d0 = done_cnt;
    do_start(4'd0, 3'd2, 3'd6, 1'b1);
    do_start(4'd12, 3'd2, 3'd2, 1'b1);
    do_start(4'd9, 3'd0, 3'd3, 1'b1);
    repeat (5) @(negedge clk);
    chk("error_pulses", err_cnt - e0, 3);
    chk("error_no_bytes", got.size(), 0);
    chk("error_no_done", done_cnt, d0);

    // largest legal request
    busy_len = 1;
    for (int i = 0; i < 25; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'd9; mem[1] = 8'd99; mem[24] = 8'd255;
    run_stream(9, 5, 5);

    // long stall after the third byte
    stall_at = 3;
    for (int i = 0; i < 6; i++) mem[i] = 8'($urandom_range(0, 255));
    run_stream(7, 2, 3);
    if (tq.size() >= 4) chk("stall_gap", (tq[3] - tq[2]) > 50, 1'b1);
    else                chk("stall_gap_len", tq.size(), 4);
    stall_at = -1;

    // reset during row 1 of a 3x3, then a fresh complete stream
    busy_len = 3;
    mem[0] = 8'd12; mem[1] = 8'd34; mem[2] = 8'd56; mem[3] = 8'd78; mem[4] = 8'd90;
    mem[5] = 8'd111; mem[6] = 8'd222; mem[7] = 8'd7; mem[8] = 8'd0;
    got.delete();
    d0 = done_cnt;
    do_start(4'd5, 3'd3, 3'd3, 1'b0);
    for (int i = 0; i < 5000 && got.size() < 19; i++) @(negedge clk);
    chk("reached_row1", got.size() >= 19, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    n0 = got.size();
    repeat (60) @(negedge clk);
    chk("no_tx_after_rst", got.size(), n0);
    chk("no_done_after_rst", done_cnt, d0);
    run_stream(5, 3, 3);

    // second start while busy is ignored
    busy_len = 2;
    for (int i = 0; i < 6; i++) mem[i] = 8'($urandom_range(0, 255));
    got.delete(); tq.delete();
    build_exp(4, 2, 3);
    d0 = done_cnt;
    e0 = err_cnt;
    do_start(4'd4, 3'd2, 3'd3, 1'b0);
    repeat (20) @(negedge clk);
    bus.start = 1'b1; bus.matrix_id = 4'd15; bus.dim_m = 3'd1; bus.dim_n = 3'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(d0);
    compare_stream();
    chk("ignored_start_no_error", err_cnt, e0);

    // random legal requests
    for (int k = 0; k < 4; k++) begin
      int id, m, n;
      id = $urandom_range(0, 9);
      m = $urandom_range(1, 5);
      n = $urandom_range(1, 5);
      busy_len = $urandom_range(0, 4);
      for (int i = 0; i < 25; i++) mem[i] = 8'($urandom_range(0, 255));
      run_stream(id, m, n);
    end

    chk("tx_start_while_busy", viol_cnt, 0);
    chk("done_with_error", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_ascii_encoder.md
MATRIX_ASCII_ENCODER -- requirements
Module: matrix_ascii_encoder

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-002 SHALL provide port rst, input, 1 bit: reset; synchronous, active-high.
REQ-003 SHALL provide port start, input, 1 bit: one-cycle request to encode one matrix.
REQ-004 SHALL provide port matrix_id, input, 4 bits: stored-matrix ID, legal range 0-9.
REQ-005 SHALL provide port dim_m, input, 3 bits: row count, legal range 1-5.
REQ-006 SHALL provide port dim_n, input, 3 bits: column count, legal range 1-5.
REQ-007 SHALL provide port elem_addr, output, 5 bits: row-major element read address, r*dim_n+c.
REQ-008 SHALL provide port elem_data, input, 8 bits: unsigned element, valid exactly 1 cycle after elem_addr is presented.
REQ-009 SHALL provide port tx_data, output, 8 bits: ASCII byte to the UART transmitter.
REQ-010 SHALL provide port tx_start, output, 1 bit: one-cycle byte-send strobe.
REQ-011 SHALL provide port tx_busy, input, 1 bit: UART transmitter busy.
REQ-012 SHALL provide port busy, output, 1 bit: high from the cycle after an accepted start until done or error.
REQ-013 SHALL provide port done, output, 1 bit: one-cycle pulse after the last byte completes.
REQ-014 SHALL provide port error, output, 1 bit: one-cycle pulse on an illegal request.

Function
REQ-015 SHALL sample matrix_id, dim_m and dim_n in the cycle start=1 with busy=0; start while busy=1 SHALL be ignored.
REQ-016 SHALL implement states IDLE, CHECK, HDR, FETCH, CONV, EMIT, WAIT, FIN.
REQ-017 SHALL run CHECK in the cycle after an accepted start; if id>9, dim_m outside 1-5, or dim_n outside 1-5, it SHALL pulse error, emit no byte, and return to IDLE.
REQ-018 SHALL emit the header bytes 'M', id digit, ':', m digit, 'x', n digit, 0x0D, 0x0A, where each digit is 0x30+value.
REQ-019 SHALL then emit rows 0..m-1: each element as unsigned decimal with no leading zeros (value 0 gives "0"), one 0x20 between elements, and 0x0D 0x0A after each row; no trailing space.
REQ-020 SHALL convert decimal via a hundreds/tens/ones split of an 8-bit value, covering 0-255 and producing 1-3 digits.
REQ-021 SHALL, in FETCH, drive elem_addr and capture elem_data the following cycle; elem_addr SHALL hold 0 when idle.
REQ-022 SHALL assert tx_start for exactly 1 cycle in EMIT, and only when tx_busy=0, with tx_data stable from that cycle until the next tx_start.
REQ-023 SHALL, in WAIT, ignore tx_busy for the first cycle after tx_start, then advance only once tx_busy=0; no byte is dropped or duplicated under any tx_busy stall length.
REQ-024 SHALL assert the first tx_start 2 cycles after an accepted start when tx_busy=0 throughout.
REQ-025 SHALL, in FIN, pulse done for 1 cycle after the final 0x0A has been released by tx_busy, then go to IDLE; done and error SHALL never be asserted together.
REQ-026 SHALL bound the element counter at m*n-1 (max 24) with no wrap-around; the row/column counters reset per request.

Reset
REQ-027 SHALL, while rst=1, force state IDLE and tx_data=0, tx_start=0, elem_addr=0, busy=0, done=0, error=0, and clear all counters.
REQ-028 SHALL, on rst mid-operation, abandon the stream with no further tx_start; the next accepted start SHALL produce a complete stream from 'M'.

Verification
REQ-029 SHALL verify: id=3, m=1, n=1, elem=0, tx_busy modeled 10 cycles per byte -> 4D 33 3A 31 78 31 0D 0A 30 0D 0A, then one done pulse.
REQ-030 SHALL verify: id=0, m=2, n=2, elems 5,10,100,255 -> header then "5 10\r\n100 255\r\n", with elem_addr sequence 0,1,2,3.
REQ-031 SHALL verify: dim_n=6, and separately id=12 -> error pulse 1 cycle after start, no tx_start, busy returns to 0.
REQ-032 SHALL verify: tx_busy held high 50 cycles after the third byte -> tx_start stays 0 until tx_busy falls, and the byte stream is unchanged.
REQ-033 SHALL verify: rst=1 during row 1 of a 3x3 -> all outputs 0 next cycle; a fresh start then yields the full 3x3 stream.
REQ-034 SHALL verify: a second start during busy -> ignored; exactly one stream and one done.
